// File: rtl/mat_dma_if.sv
// rtl/mat_dma_if.sv - command/status and RAM-port bundle for the matrix word copier.
interface mat_dma_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              ram_enable;
  logic              ram_readwrite;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  start, src_addr, dst_addr, len, ram_rdata,
    output busy, done, ram_enable, ram_readwrite, ram_address, ram_wdata
  );

  modport slave (
    output start, src_addr, dst_addr, len, ram_rdata,
    input  busy, done, ram_enable, ram_readwrite, ram_address, ram_wdata
  );
endinterface

// File: rtl/mat_dma.sv
// rtl/mat_dma.sv - single-port RAM word copier, 3 cycles per word (READ, WAIT, WRITE).
// Optional MAT_DMA_TRANSPOSE_EN stores each captured 4x4 x 16-bit word transposed.
module mat_dma #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 4
) (
  input  logic      clk,
  input  logic      reset,
  mat_dma_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [ADDR_W:0]   len_q, idx_q;
  logic [DATA_W-1:0] data_q, captured;
  logic              last_word;

  assign last_word     = (idx_q + (ADDR_W+1)'(1)) == len_q;
  assign bus.ram_wdata = data_q;

  always_comb begin
    captured = bus.ram_rdata;
`ifdef MAT_DMA_TRANSPOSE_EN
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        captured[(4*c+r)*16 +: 16] = bus.ram_rdata[(4*r+c)*16 +: 16];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            src_q <= bus.src_addr;
            dst_q <= bus.dst_addr;
            len_q <= bus.len;
            idx_q <= '0;
          end
        end
        WAIT:    data_q <= captured;
        WRITE:   idx_q  <= idx_q + (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  // Address sums are ADDR_W wide, so they wrap modulo the RAM size.
  always_comb begin
    state_next        = state;
    bus.busy          = 1'b0;
    bus.done          = 1'b0;
    bus.ram_enable    = 1'b0;
    bus.ram_readwrite = 1'b1;
    bus.ram_address   = '0;
    case (state)
      IDLE: begin
        if (bus.start) state_next = (bus.len == '0) ? DONE : READ;
      end
      READ: begin
        bus.busy        = 1'b1;
        bus.ram_enable  = 1'b1;
        bus.ram_address = src_q + idx_q[ADDR_W-1:0];
        state_next      = WAIT;
      end
      WAIT: begin
        bus.busy   = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        bus.busy          = 1'b1;
        bus.ram_enable    = 1'b1;
        bus.ram_readwrite = 1'b0;
        bus.ram_address   = dst_q + idx_q[ADDR_W-1:0];
        state_next        = last_word ? DONE : READ;
      end
      DONE: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule
